// File: rtl/uart_receiver.sv
// UART receive stage: 8N1-style framing, MSB-first data, oversampled line.
// Validates start and stop bits and hands each word to the host through a
// valid/ack handshake, flagging framing errors and overruns as one-cycle pulses.
module uart_receiver #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 rx_ack,
   output logic [WORD_SIZE-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned TICK_LIMIT = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned SW         = $clog2(OVERSAMPLE);
   localparam int unsigned BW         = $clog2(WORD_SIZE) + 1;

   localparam logic [15:0]   TICK_LAST = 16'(TICK_LIMIT - 1);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SAMP_ONE  = SW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e                 state;
   logic                   rx_meta;
   logic                   rx_s;
   logic [15:0]            tick_cnt;
   logic                   tick;
   logic [SW-1:0]          samp_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [WORD_SIZE-1:0]   shreg;
   logic                   deliver;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Oversample tick divider; parked at zero while idle so sampling phase follows the start edge.
   always_ff @(posedge clk) begin
      if (rst || state == StIdle || state == StBreak || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);
   assign busy = (state != StIdle);

   // Frame state machine plus the host-side delivery and handshake registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         deliver   <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         deliver   <= 1'b0;

         // A delivery takes precedence over a plain ack; an ack in the same cycle frees the slot.
         if (deliver) begin
            if (!rx_valid) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else if (rx_ack) begin
               rx_data  <= shreg;
            end else begin
               overrun  <= 1'b1;
            end
         end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
         end

         case (state)
            StIdle: begin
               if (!rx_s) begin
                  state    <= StStart;
                  samp_cnt <= '0;
               end
            end
            StStart: begin
               if (tick) begin
                  if (samp_cnt == SAMP_MID) begin
                     samp_cnt <= '0;
                     if (!rx_s) begin
                        state   <= StData;
                        bit_cnt <= '0;
                     end else begin
                        state   <= StIdle;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + SAMP_ONE;
                  end
               end
            end
            StData: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt <= '0;
                     shreg    <= {shreg[WORD_SIZE-2:0], rx_s};
                     if (bit_cnt == BIT_LAST) begin
                        state <= StStop;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + SAMP_ONE;
                  end
               end
            end
            StStop: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt <= '0;
                     // Returning to idle at mid stop bit lets a back-to-back start bit be caught.
                     if (rx_s) begin
                        deliver   <= 1'b1;
                        state     <= StIdle;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= StBreak;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + SAMP_ONE;
                  end
               end
            end
            StBreak: begin
               if (rx_s) begin
                  state <= StIdle;
               end
            end
            default: begin
               state    <= StIdle;
               samp_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scoreboard of expected words, pulse counters
// for frame_err/overrun/busy, fixed-length stimulus so every run terminates.
module tb_uart_receiver;

   localparam int BIT_CLK = 32;   // 3.2 MHz / 100 kbaud
   // Delivery cycle sits one cycle before rx_valid would rise: 2 sync + 9.5 bits + state entry.
   localparam int DELIVER_AT = 307;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_words  = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;
   int n_busy   = 0;
   int w0, f0, o0, b0;

   logic [7:0] sb[$];

   uart_receiver #(
      .CLOCK_FREQ(3_200_000),
      .BAUD_RATE (100_000),
      .WORD_SIZE (8),
      .OVERSAMPLE(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_ack   (rx_ack),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_val);
      rx = 1'b0;
      idle(BIT_CLK);
      for (int i = 7; i >= 0; i--) begin
         rx = data[i];
         idle(BIT_CLK);
      end
      rx = stop_val;
      idle(BIT_CLK);
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   task automatic snap();
      w0 = n_words;
      f0 = n_ferr;
      o0 = n_ovr;
      b0 = n_busy;
   endtask

   // Monitor: pops the scoreboard on every new word and counts flag pulses.
   initial begin
      logic       prev_v;
      logic       prev_b;
      logic [7:0] prev_d;
      logic [7:0] exp;
      prev_v = 1'b0;
      prev_b = 1'b0;
      prev_d = '0;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1 && (!prev_v || rx_data !== prev_d)) begin
            n_words++;
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            check("word", {24'd0, rx_data}, {24'd0, exp});
         end
         if (frame_err === 1'b1) n_ferr++;
         if (overrun === 1'b1) n_ovr++;
         if (busy === 1'b1 && !prev_b) n_busy++;
         prev_v = (rx_valid === 1'b1);
         prev_b = (busy === 1'b1);
         prev_d = rx_data;
      end
   end

   initial begin
      rst    = 1'b1;
      rx     = 1'b1;
      rx_ack = 1'b0;
      idle(4);
      check("rst_data", {24'd0, rx_data}, 32'd0);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      idle(10);

      // Single frame 0xA5
      snap();
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle(10);
      check("a5_words", n_words - w0, 1);
      check("a5_valid", {31'd0, rx_valid}, 32'd1);
      check("a5_ferr", n_ferr - f0, 0);
      check("a5_ovr", n_ovr - o0, 0);
      ack_pulse();
      check("a5_ack_clr", {31'd0, rx_valid}, 32'd0);

      // Start glitch: 6 clk low
      snap();
      rx = 1'b0;
      idle(6);
      rx = 1'b1;
      idle(40);
      check("gl_busy_pulse", n_busy - b0, 1);
      check("gl_busy_end", {31'd0, busy}, 32'd0);
      check("gl_valid", {31'd0, rx_valid}, 32'd0);
      check("gl_words", n_words - w0, 0);
      check("gl_ferr", n_ferr - f0, 0);

      // Framing error on 0x3C, line held low, then a clean 0x81
      snap();
      send_frame(8'h3C, 1'b0);
      idle(200);
      rx = 1'b1;
      idle(40);
      check("fe_pulses", n_ferr - f0, 1);
      check("fe_words", n_words - w0, 0);
      check("fe_valid", {31'd0, rx_valid}, 32'd0);
      sb.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      idle(10);
      check("fe_next_words", n_words - w0, 1);
      check("fe_next_data", {24'd0, rx_data}, 32'h81);
      check("fe_next_ferr", n_ferr - f0, 1);
      ack_pulse();

      // Overrun: 0x11 then 0x22 back-to-back without ack
      snap();
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(20);
      check("ov_pulses", n_ovr - o0, 1);
      check("ov_words", n_words - w0, 1);
      check("ov_data_kept", {24'd0, rx_data}, 32'h11);
      check("ov_valid", {31'd0, rx_valid}, 32'd1);
      ack_pulse();
      check("ov_ack_clr", {31'd0, rx_valid}, 32'd0);
      sb.push_back(8'h33);
      send_frame(8'h33, 1'b1);
      idle(10);
      check("ov_next_data", {24'd0, rx_data}, 32'h33);
      check("ov_next_ovr", n_ovr - o0, 1);
      ack_pulse();

      // Ack coincident with delivery of the second word
      snap();
      sb.push_back(8'h11);
      sb.push_back(8'h22);
      fork
         begin
            send_frame(8'h11, 1'b1);
            send_frame(8'h22, 1'b1);
         end
         begin
            idle(10 * BIT_CLK + DELIVER_AT);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
         end
      join
      idle(10);
      check("ad_words", n_words - w0, 2);
      check("ad_data", {24'd0, rx_data}, 32'h22);
      check("ad_valid", {31'd0, rx_valid}, 32'd1);
      check("ad_ovr", n_ovr - o0, 0);

      // Reset at mid bit 4 of 0xFF (rx_valid still holds 0x22), then clean 0x5A
      snap();
      rx = 1'b0;
      idle(BIT_CLK);
      rx = 1'b1;
      idle(4 * BIT_CLK + BIT_CLK / 2);
      rst = 1'b1;
      idle(3);
      check("mr_data", {24'd0, rx_data}, 32'd0);
      check("mr_valid", {31'd0, rx_valid}, 32'd0);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_ferr", {31'd0, frame_err}, 32'd0);
      check("mr_ovr", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      idle(40);
      check("mr_no_word", n_words - w0, 0);
      sb.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      idle(10);
      check("mr_words", n_words - w0, 1);
      check("mr_next_data", {24'd0, rx_data}, 32'h5A);
      check("mr_flags", (n_ferr - f0) + (n_ovr - o0), 0);

      check("sb_left", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
